alu_mc: RTL and testbench

Parametrised, handshaked successor to the single-cycle 32-bit ALU, extended to the full RV32I integer operation set. Sits between decode/operand-read and writeback in the execute stage.
- Logic, arithmetic and compare ops complete in one cycle.
- Shifts run iteratively, SHIFT_STEP bits per cycle, trading latency for area.
- valid/ready on both sides, so the pipeline can stall the ALU and the ALU can stall the pipeline.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_core.sv | 69 ++++++
 rtl/alu_mc.sv | 159 +++++++++++++++
 tb/tb_alu_mc.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the multi-cycle RV32I-style ALU.
//   - Operation codes, encoded as {funct7[5], funct3}.
//   - Bit positions inside the 5-bit status word {LTU, V, C, N, Z}.
//   - Control FSM state type.
//   - is_shift(): identifies the ops that use the iterative shifter.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  localparam int ST_Z   = 0;
  localparam int ST_N   = 1;
  localparam int ST_C   = 2;
  localparam int ST_V   = 3;
  localparam int ST_LTU = 4;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational datapath of the ALU.
//   a, b, op  -> res, c, v : single-cycle ops (add/sub/compare/logic).
//                            Shift codes pass a through; they only reach this
//                            path with a zero shift amount.
//   sh_in, sh_op, sh_d -> sh_out : one step of an iterative shift by sh_d bits.
module alu_core
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = 5
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      op,
  output logic [XLEN-1:0] res,
  output logic            c,
  output logic            v,
  input  logic [XLEN-1:0] sh_in,
  input  logic [3:0]      sh_op,
  input  logic [SHW-1:0]  sh_d,
  output logic [XLEN-1:0] sh_out
);

  logic signed [XLEN-1:0] a_s;
  logic signed [XLEN-1:0] b_s;
  logic signed [XLEN-1:0] sh_in_s;
  logic                   sub;
  logic        [XLEN-1:0] b_eff;
  logic        [XLEN:0]   sum;

  assign a_s     = a;
  assign b_s     = b;
  assign sh_in_s = sh_in;

  // Subtraction is A + ~B + 1, so C = 1 means "no borrow".
  assign sub   = (op == ALU_SUB);
  assign b_eff = sub ? ~b : b;
  assign sum   = {1'b0, a} + {1'b0, b_eff} + {{XLEN{1'b0}}, sub};

  always_comb begin
    res = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (op)
      ALU_ADD, ALU_SUB: begin
        res = sum[XLEN-1:0];
        c   = sum[XLEN];
        // Overflow: both addends share a sign that differs from the sum's.
        v   = (a[XLEN-1] == b_eff[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
      end
      ALU_SLT:  res = {{(XLEN-1){1'b0}}, (a_s < b_s)};
      ALU_SLTU: res = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:  res = a ^ b;
      ALU_OR:   res = a | b;
      ALU_AND:  res = a & b;
      ALU_SLL, ALU_SRL, ALU_SRA: res = a;
      default:  res = '0;
    endcase
  end

  always_comb begin
    case (sh_op)
      ALU_SLL: sh_out = sh_in << sh_d;
      ALU_SRA: sh_out = sh_in_s >>> sh_d;
      default: sh_out = sh_in >> sh_d;
    endcase
  end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: handshaked execute-stage ALU.
//   clk, rst          : clock and asynchronous active-high reset
//   in_valid/in_ready : operand handshake (A, B, op)
//   out_valid/out_ready : result handshake (result, status)
//   status            : {LTU, V, C, N, Z}
//   busy              : an iterative shift is in progress
// Non-shift ops and zero-distance shifts complete at the accept edge.
// Shifts with a non-zero distance iterate SHIFT_STEP bits per cycle.
module alu_mc
  import alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [3:0]      op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      status,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);
  // A shift distance never exceeds XLEN-1, so capping the per-cycle step
  // at XLEN-1 gives the same min(rem, SHIFT_STEP) while fitting in SHW bits.
  localparam int              STEP_LIM = (SHIFT_STEP >= XLEN) ? (XLEN - 1) : SHIFT_STEP;
  localparam logic [SHW-1:0] STEP_CAP = STEP_LIM[SHW-1:0];

  state_e            state_q, state_d;
  logic [XLEN-1:0]   work_q, work_d;
  logic [SHW-1:0]    rem_q, rem_d;
  logic [3:0]        kind_q, kind_d;
  logic              ltu_q, ltu_d;
  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        status_q, status_d;

  logic [SHW-1:0]    shamt;
  logic [SHW-1:0]    step;
  logic [SHW-1:0]    rem_next;
  logic              accept;
  logic [XLEN-1:0]   core_res;
  logic              core_c;
  logic              core_v;
  logic [XLEN-1:0]   sh_out;

  function automatic logic [4:0] mk_status(input logic [XLEN-1:0] r, input logic c,
                                           input logic v, input logic ltu);
    logic [4:0] s;
    s         = '0;
    s[ST_Z]   = (r == '0);
    s[ST_N]   = r[XLEN-1];
    s[ST_C]   = c;
    s[ST_V]   = v;
    s[ST_LTU] = ltu;
    return s;
  endfunction

  assign shamt     = B[SHW-1:0];
  assign in_ready  = !rst && (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign step      = (rem_q > STEP_CAP) ? STEP_CAP : rem_q;
  assign rem_next  = rem_q - step;

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign status    = status_q;
  assign busy      = (state_q == S_SHIFT);

  alu_core #(
    .XLEN (XLEN),
    .SHW  (SHW)
  ) u_core (
    .a      (A),
    .b      (B),
    .op     (op),
    .res    (core_res),
    .c      (core_c),
    .v      (core_v),
    .sh_in  (work_q),
    .sh_op  (kind_q),
    .sh_d   (step),
    .sh_out (sh_out)
  );

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    rem_d       = rem_q;
    kind_d      = kind_q;
    ltu_d       = ltu_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    status_d    = status_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_shift(op) && (shamt != '0)) begin
            work_d  = A;
            rem_d   = shamt;
            kind_d  = op;
            // LTU refers to the original operands, so capture it now.
            ltu_d   = (A < B);
            state_d = S_SHIFT;
          end else begin
            result_d    = core_res;
            status_d    = mk_status(core_res, core_c, core_v, (A < B));
            out_valid_d = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        work_d = sh_out;
        rem_d  = rem_next;
        if (rem_next == '0) begin
          result_d    = sh_out;
          status_d    = mk_status(sh_out, 1'b0, 1'b0, ltu_q);
          out_valid_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      work_q      <= '0;
      rem_q       <= '0;
      kind_q      <= ALU_ADD;
      ltu_q       <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      status_q    <= '0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      rem_q       <= rem_d;
      kind_q      <= kind_d;
      ltu_q       <= ltu_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      status_q    <= status_d;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed, table-driven bench for alu_mc.
// u_dut4 (SHIFT_STEP=4) runs the vector table and the backpressure sequence;
// u_dut1 (SHIFT_STEP=1) runs the reset-during-shift sequence.
module tb_alu_mc;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [4:0]  st;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        iv4 = 1'b0, ir4, ov4, or4 = 1'b1, busy4;
  logic [31:0] a4 = '0, b4 = '0, r4;
  logic [3:0]  op4 = '0;
  logic [4:0]  st4;

  logic        iv1 = 1'b0, ir1, ov1, or1 = 1'b1, busy1;
  logic [31:0] a1 = '0, b1 = '0, r1;
  logic [3:0]  op1 = '0;
  logic [4:0]  st1;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t vt[16];

  always #5 clk = ~clk;

  alu_mc #(.XLEN(32), .SHIFT_STEP(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .A(a4), .B(b4), .op(op4),
    .out_valid(ov4), .out_ready(or4), .result(r4), .status(st4), .busy(busy4)
  );

  alu_mc #(.XLEN(32), .SHIFT_STEP(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .A(a1), .B(b1), .op(op1),
    .out_valid(ov1), .out_ready(or1), .result(r1), .status(st1), .busy(busy1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int  n;
    int  bcnt;
    int  viol;
    bit  seen;
    @(negedge clk);
    iv4 = 1'b1; op4 = v.op; a4 = v.a; b4 = v.b;
    #1;
    chk({v.name, "/in_ready"}, {31'b0, ir4}, 32'd1);
    @(posedge clk);
    #1 iv4 = 1'b0;
    seen = 1'b0; bcnt = 0; viol = 0; n = 1;
    while (n <= 60 && !seen) begin
      @(negedge clk);
      if (ov4) begin
        seen = 1'b1;
      end else begin
        if (busy4) bcnt++;
        if (ir4) viol++;
        n++;
      end
    end
    if (!seen) begin
      chk({v.name, "/timeout"}, 32'd0, 32'd1);
    end else begin
      chk({v.name, "/result"}, v.res, v.res == r4 ? v.res : r4);
      chk({v.name, "/status"}, {27'b0, st4}, {27'b0, v.st});
      chk({v.name, "/latency"}, n, v.lat);
      chk({v.name, "/busy_cycles"}, bcnt, v.lat - 1);
      chk({v.name, "/ready_while_busy"}, viol, 32'd0);
    end
  endtask

  initial begin
    int ov_seen;

    //            name          op       a             b             result        status    lat
    vt[0]  = '{"add_9_10",    4'b0000, 32'd9,        32'd10,       32'd19,       5'b10000, 1};
    vt[1]  = '{"sub_9_10",    4'b1000, 32'd9,        32'd10,       32'hFFFFFFFF, 5'b10010, 1};
    vt[2]  = '{"sub_10_10",   4'b1000, 32'd10,       32'd10,       32'd0,        5'b00101, 1};
    vt[3]  = '{"slt_m1_1",    4'b0010, 32'hFFFFFFFF, 32'd1,        32'd1,        5'b00000, 1};
    vt[4]  = '{"sltu_m1_1",   4'b0011, 32'hFFFFFFFF, 32'd1,        32'd0,        5'b00001, 1};
    vt[5]  = '{"add_ovf",     4'b0000, 32'h7FFFFFFF, 32'd1,        32'h80000000, 5'b01010, 1};
    vt[6]  = '{"illegal",     4'b1111, 32'd5,        32'd3,        32'd0,        5'b00001, 1};
    vt[7]  = '{"xor",         4'b0100, 32'h0000F0F0, 32'h00000FF0, 32'h0000FF00, 5'b00000, 1};
    vt[8]  = '{"or_6_1",      4'b0110, 32'd6,        32'd1,        32'd7,        5'b00000, 1};
    vt[9]  = '{"and_zero",    4'b0111, 32'hFFFF0000, 32'h0000FFFF, 32'd0,        5'b00001, 1};
    vt[10] = '{"sll_b0",      4'b0001, 32'd1,        32'd0,        32'd1,        5'b00000, 1};
    vt[11] = '{"add_carry",   4'b0000, 32'hFFFFFFFF, 32'd1,        32'd0,        5'b00101, 1};
    vt[12] = '{"srl_b32",     4'b0101, 32'h80000000, 32'h00000020, 32'h80000000, 5'b00010, 1};
    vt[13] = '{"sub_ovf",     4'b1000, 32'h80000000, 32'd1,        32'h7FFFFFFF, 5'b01100, 1};
    vt[14] = '{"sll_3_4",     4'b0001, 32'd3,        32'd4,        32'h00000030, 5'b10000, 2};
    vt[15] = '{"sra_31",      4'b1101, 32'h80000000, 32'd31,       32'hFFFFFFFF, 5'b00010, 9};

    // Reset state, sampled while rst is still high.
    @(negedge clk);
    @(negedge clk);
    chk("rst/in_ready", {31'b0, ir4}, 32'd0);
    chk("rst/out_valid", {31'b0, ov4}, 32'd0);
    chk("rst/result", r4, 32'd0);
    chk("rst/status", {27'b0, st4}, 32'd0);
    chk("rst/busy", {31'b0, busy4}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst/in_ready_after", {31'b0, ir4}, 32'd1);

    for (int i = 0; i < 16; i++) begin
      run_vec(vt[i]);
    end

    // SRL with upper B bits set: shamt = 5, so 2 shift cycles at STEP=4.
    begin
      vec_t v;
      v = '{"srl_b37", 4'b0101, 32'hF0000000, 32'h00000025, 32'h07800000, 5'b00000, 3};
      run_vec(v);
    end

    // Backpressure: result held while out_ready=0, then drain-and-accept.
    @(negedge clk);
    or4 = 1'b0;
    iv4 = 1'b1; op4 = 4'b0111; a4 = 32'd1; b4 = 32'd1;
    @(posedge clk);
    #1 iv4 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("bp/out_valid_%0d", k), {31'b0, ov4}, 32'd1);
      chk($sformatf("bp/result_%0d", k), r4, 32'd1);
      chk($sformatf("bp/in_ready_%0d", k), {31'b0, ir4}, 32'd0);
    end
    @(negedge clk);
    or4 = 1'b1;
    iv4 = 1'b1; op4 = 4'b0110; a4 = 32'd6; b4 = 32'd1;
    #1;
    chk("bp/in_ready_release", {31'b0, ir4}, 32'd1);
    @(posedge clk);
    #1 iv4 = 1'b0;
    @(negedge clk);
    chk("bp/out_valid_or", {31'b0, ov4}, 32'd1);
    chk("bp/result_or", r4, 32'd7);
    chk("bp/status_or", {27'b0, st4}, 32'd0);
    @(negedge clk);
    chk("bp/drained", {31'b0, ov4}, 32'd0);

    // Reset in the middle of an iterative shift on the STEP=1 instance.
    @(negedge clk);
    iv1 = 1'b1; op1 = 4'b0101; a1 = 32'hF0000000; b1 = 32'd20;
    @(posedge clk);
    #1 iv1 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("mid/busy_before", {31'b0, busy1}, 32'd1);
    chk("mid/in_ready_before", {31'b0, ir1}, 32'd0);
    rst = 1'b1;
    #1;
    chk("mid/busy_in_rst", {31'b0, busy1}, 32'd0);
    chk("mid/in_ready_in_rst", {31'b0, ir1}, 32'd0);
    chk("mid/result_in_rst", r1, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ov_seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (ov1) ov_seen++;
    end
    chk("mid/no_output", ov_seen, 32'd0);
    @(negedge clk);
    iv1 = 1'b1; op1 = 4'b0000; a1 = 32'd1; b1 = 32'd1;
    @(posedge clk);
    #1 iv1 = 1'b0;
    @(negedge clk);
    chk("mid/add_valid", {31'b0, ov1}, 32'd1);
    chk("mid/add_result", r1, 32'd2);
    chk("mid/add_status", {27'b0, st1}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
